// File: rtl/ext_bus_ctrl.sv
// External peripheral bus decoder: three peripheral slots plus an internal status/control slot.
// Optional idle-bus watchdog is built when EXT_BUS_WDT_EN is defined.
module ext_bus_ctrl #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_2000,
  parameter int unsigned WDT_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic        we_i,
  input  logic        re_i,
  output logic [31:0] rdata_o,
  output logic [2:0]  slot_we_o,
  output logic [2:0]  slot_sel_o,
  output logic [1:0]  reg_sel_o,
  output logic [31:0] slot_wdata_o,
  input  logic [31:0] slot0_rdata_i,
  input  logic [31:0] slot1_rdata_i,
  input  logic [31:0] slot2_rdata_i,
  output logic        err_irq_o
);

  if (BASE_ADDR[5:0] != 6'd0 || WDT_CYCLES == 0) begin : g_bad_cfg
    $error("ext_bus_ctrl: BASE_ADDR must be 64-byte aligned and WDT_CYCLES non-zero");
  end

  logic        access, valid, err, ctrl_wr, clr, wdt_flag;
  logic [1:0]  slot;
  logic        err_sticky_q, err_sticky_d;
  logic [7:0]  err_count_q, err_count_d;
  logic [31:0] last_err_q, last_err_d;
  logic [15:0] rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;
  logic        irq_en_q, irq_en_d;
  logic        err_irq_q, err_irq_d;

  always_comb begin
    access  = we_i | re_i;
    valid   = access && (addr_i[31:6] == BASE_ADDR[31:6]) && (addr_i[1:0] == 2'b00);
    err     = access && !valid;
    slot    = addr_i[5:4];
    ctrl_wr = valid && we_i && (slot == 2'd3) && (addr_i[3:2] == 2'd3);
    clr     = ctrl_wr && wdata_i[1];

    // Strobes are forced low for as long as reset is held, independent of the clock.
    slot_sel_o = 3'b000;
    if (valid && (slot != 2'd3) && !rst) slot_sel_o[slot] = 1'b1;
    slot_we_o    = slot_sel_o & {3{we_i}};
    reg_sel_o    = addr_i[3:2];
    slot_wdata_o = wdata_i;

    rdata_o = 32'h0;
    if (valid) begin
      unique case (slot)
        2'd0: rdata_o = slot0_rdata_i;
        2'd1: rdata_o = slot1_rdata_i;
        2'd2: rdata_o = slot2_rdata_i;
        default: begin
          unique case (addr_i[3:2])
            2'd0:    rdata_o = {16'h0, err_count_q, 6'h0, wdt_flag, err_sticky_q};
            2'd1:    rdata_o = last_err_q;
            2'd2:    rdata_o = {rd_cnt_q, wr_cnt_q};
            default: rdata_o = {31'h0, irq_en_q};
          endcase
        end
      endcase
    end
  end

  always_comb begin
    err_sticky_d = err_sticky_q;
    err_count_d  = err_count_q;
    last_err_d   = last_err_q;
    rd_cnt_d     = rd_cnt_q;
    wr_cnt_d     = wr_cnt_q;
    irq_en_d     = irq_en_q;
    err_irq_d    = (err_sticky_q | wdt_flag) & irq_en_q;

    if (ctrl_wr) irq_en_d = wdata_i[0];
    if (err) begin
      err_sticky_d = 1'b1;
      if (err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
      last_err_d = addr_i;
    end
    if (valid && (slot != 2'd3)) begin
      if (we_i) wr_cnt_d = wr_cnt_q + 16'd1;
      else      rd_cnt_d = rd_cnt_q + 16'd1;
    end
    if (clr) begin
      err_sticky_d = 1'b0;
      err_count_d  = 8'h0;
      last_err_d   = 32'h0;
      rd_cnt_d     = 16'h0;
      wr_cnt_d     = 16'h0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_sticky_q <= 1'b0;
      err_count_q  <= 8'h0;
      last_err_q   <= 32'h0;
      rd_cnt_q     <= 16'h0;
      wr_cnt_q     <= 16'h0;
      irq_en_q     <= 1'b0;
      err_irq_q    <= 1'b0;
    end else begin
      err_sticky_q <= err_sticky_d;
      err_count_q  <= err_count_d;
      last_err_q   <= last_err_d;
      rd_cnt_q     <= rd_cnt_d;
      wr_cnt_q     <= wr_cnt_d;
      irq_en_q     <= irq_en_d;
      err_irq_q    <= err_irq_d;
    end
  end

  assign err_irq_o = err_irq_q;

`ifdef EXT_BUS_WDT_EN
  localparam int unsigned WdtW = $clog2(WDT_CYCLES + 1);
  localparam logic [WdtW-1:0] WdtLimit = WdtW'(WDT_CYCLES);

  logic [WdtW-1:0] wdt_cnt_q, wdt_cnt_d;
  logic            wdt_flag_q, wdt_flag_d;

  always_comb begin
    wdt_cnt_d  = wdt_cnt_q;
    wdt_flag_d = wdt_flag_q;
    if (valid)                       wdt_cnt_d = '0;
    else if (wdt_cnt_q != WdtLimit)  wdt_cnt_d = wdt_cnt_q + 1'b1;
    if (wdt_cnt_d == WdtLimit)       wdt_flag_d = 1'b1;
    if (clr)                         wdt_flag_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wdt_cnt_q  <= '0;
      wdt_flag_q <= 1'b0;
    end else begin
      wdt_cnt_q  <= wdt_cnt_d;
      wdt_flag_q <= wdt_flag_d;
    end
  end

  assign wdt_flag = wdt_flag_q;
`else
  assign wdt_flag = 1'b0;
`endif

endmodule

// File: doc/ext_bus_ctrl.md
Name: ext_bus_ctrl

Overview:
- Address decoder and bus controller for the CPU external peripheral bus.
- Splits one 64-byte ext window into three peripheral slots plus one internal status/control slot, and steers write strobes and read-back data.
- Counts accesses, traps unmapped or misaligned accesses and raises an error interrupt.
- Sits between the microcontroller ext bus (address/data/we) and the peripheral instances such as top_perifericos.

Parameters:
- BASE_ADDR, 32'h0000_2000, base of ext window; must be aligned to 64 bytes.
- WDT_CYCLES, 1_000_000, idle-cycle limit for the optional bus watchdog (100 ms at 10 MHz).

Ports:
- clk  in  1  system clock (10 MHz domain).
- rst  in  1  asynchronous, active-high reset.
- addr_i  in  32  CPU ext address.
- wdata_i  in  32  CPU write data.
- we_i  in  1  CPU write enable.
- re_i  in  1  CPU read enable.
- rdata_o  out  32  read data to CPU.
- slot_we_o  out  3  per-slot write strobe for slots 0-2.
- slot_sel_o  out  3  one-hot slot select for slots 0-2.
- reg_sel_o  out  2  register index within slot, equal to addr_i[3:2].
- slot_wdata_o  out  32  write data to peripherals, equal to wdata_i.
- slot0_rdata_i, slot1_rdata_i, slot2_rdata_i  in  32 each  peripheral read-back.
- err_irq_o  out  1  error interrupt, registered.

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high; it clears every register immediately.
- Access definition: an access occurs in any cycle with we_i or re_i high. If both are high, the access is a write. The bus carries at most one access per cycle.
- Valid access: addr_i[31:6] equals BASE_ADDR[31:6] and addr_i[1:0] equals 0.
  - Slot index is addr_i[5:4]; register index is addr_i[3:2].
- Error access: any access that is not valid.
- Decode is combinational, with zero latency:
  - slot_sel_o is the one-hot of the slot index when the access is valid and the slot is 0-2; otherwise 0.
  - slot_we_o equals slot_sel_o AND we_i.
  - rdata_o is slotN_rdata_i for slots 0-2 and the internal register for slot 3.
  - rdata_o is 0 for error accesses and for cycles with no access.
- Slot 3 internal registers (all update on the rising edge):
  - reg0 STATUS, read-only: [0] err_sticky; [1] wdt_flag (optional feature); [15:8] err_count, 8-bit, saturating at 255; other bits 0.
  - reg1 LAST_ERR_ADDR, read-only: addr_i captured on every error access.
  - reg2 ACC_CNT, read-only: [31:16] read count and [15:0] write count of valid slot 0-2 accesses. Both are 16-bit and wrap from 0xFFFF to 0.
  - reg3 CTRL, read/write: [0] irq_en. [1] clear: self-clearing and reads as 0. Writing clear=1 zeroes err_sticky, err_count, LAST_ERR_ADDR, ACC_CNT and wdt_flag in that cycle; irq_en takes the written bit 0.
- Writes to reg0-reg2 are ignored. They are not errors and not counted.
- Accesses to slot 3 are never counted in ACC_CNT.
- Error access effects: err_sticky set to 1, err_count incremented unless already 255, LAST_ERR_ADDR updated. No strobe is issued.
- err_irq_o is registered and equals err_sticky AND irq_en, one cycle after either bit changes.
- Reset values: rdata_o 0 (no access pending), slot_we_o 0, slot_sel_o 0, err_irq_o 0, all internal registers 0.
- Reset mid-access: any strobe is gated low while rst is high.
- Clear and error cannot coincide because the bus is single-access.

Optional Feature:
- Macro: EXT_BUS_WDT_EN.
- When defined:
  - A counter of consecutive cycles with no valid access runs, reset to 0 by each valid access.
  - When the counter reaches WDT_CYCLES, wdt_flag is set (sticky) and the counter holds.
  - err_irq_o becomes (err_sticky OR wdt_flag) AND irq_en.
- When undefined: no counter is present, STATUS[1] reads 0 and err_irq_o is unchanged.

Test Plan:
- Reset, then write to BASE+0x18 with data 0x5 -> slot_we_o 3'b010, reg_sel_o 2, slot_wdata_o 0x5, same cycle; next read of BASE+0x38 returns 0x0000_0001.
- Read 0x0000_3000 -> rdata_o 0, no strobe; STATUS reads 0x0000_0101; LAST_ERR_ADDR reads 0x3000; err_irq_o 0. Then write 0x1 to CTRL -> err_irq_o 1 one cycle later.
- Issue 300 reads to BASE+0x02 (misaligned) -> err_count saturates at 0xFF, STATUS 0x0000_FF01, no slot strobes.
- With irq asserted, write 0x3 to CTRL -> STATUS 0, ACC_CNT 0, CTRL reads 0x1, err_irq_o 0 next cycle.
- Assert rst asynchronously mid-write to BASE+0x04 -> slot_we_o drops without waiting for a clock edge, all registers read 0 after release.
- EXT_BUS_WDT_EN defined with WDT_CYCLES=8 and irq_en=1: 8 idle cycles -> STATUS[1]=1, err_irq_o 1. With a valid access at idle cycle 7, no flag is set.
